// File: rtl/qpsk_mapper.sv
// qpsk_mapper: Gray-coded QPSK symbol mapper with per-symbol sample hold.
// Consumes one dibit every SPS cycles while symbol_valid stays high and emits
// SPS identical I/Q samples per symbol. A burst ends cleanly when no symbol is
// waiting at a symbol boundary.
// Optional feature: define QPSK_DIFF_ENCODE_EN to accumulate the Gray index
// into the phase (differential encoding); the phase restarts at 0 per burst.
module qpsk_mapper #(
  parameter int SPS  = 8,
  parameter int IQ_W = 12,
  parameter int AMP  = 1448
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             symbol_data,
  input  logic                   symbol_valid,
  output logic                   mod_req,
  output logic signed [IQ_W-1:0] i_out,
  output logic signed [IQ_W-1:0] q_out,
  output logic                   sample_valid,
  output logic                   busy
);

  localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);
  localparam logic signed [IQ_W-1:0] AMP_POS = IQ_W'(AMP);
  localparam logic signed [IQ_W-1:0] AMP_NEG = -AMP_POS;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state_p1, state_nxt;
  logic [CNT_W-1:0]       sample_cnt, cnt_nxt;
  logic                   capture;
  logic [1:0]             p_nxt;
  logic signed [IQ_W-1:0] i_p1, q_p1, i_nxt, q_nxt;
  logic                   vld_p1, vld_nxt;
  logic                   req_p1, req_nxt;

  // Gray index of a dibit: adjacent constellation points differ by one bit.
  function automatic logic [1:0] gray_index(input logic [1:0] dibit);
    case (dibit)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // In-phase component: positive for phases 0 and 3.
  function automatic logic signed [IQ_W-1:0] map_i(input logic [1:0] p);
    return (p == 2'd0 || p == 2'd3) ? AMP_POS : AMP_NEG;
  endfunction

  // Quadrature component: positive for phases 0 and 1.
  function automatic logic signed [IQ_W-1:0] map_q(input logic [1:0] p);
    return (p == 2'd0 || p == 2'd1) ? AMP_POS : AMP_NEG;
  endfunction

`ifdef QPSK_DIFF_ENCODE_EN
  logic [1:0] p_p1;
  logic [1:0] p_base;

  // Phase accumulator restarts at 0 when a burst begins from IDLE.
  always_comb begin
    p_base = (state_p1 == IDLE) ? 2'd0 : p_p1;
    p_nxt  = p_base + gray_index(symbol_data);
  end

  // Phase accumulator register, advanced on every symbol capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_p1 <= 2'd0;
    end else if (capture) begin
      p_p1 <= p_nxt;
    end
  end
`else
  // Phase is the Gray index of the symbol being captured; no stored state.
  always_comb begin
    p_nxt = gray_index(symbol_data);
  end
`endif

  // Next-state, sample counter and next output sample selection.
  always_comb begin
    state_nxt = state_p1;
    cnt_nxt   = sample_cnt;
    capture   = 1'b0;
    i_nxt     = i_p1;
    q_nxt     = q_p1;
    vld_nxt   = vld_p1;
    req_nxt   = 1'b0;
    case (state_p1)
      IDLE: begin
        if (symbol_valid) begin
          capture   = 1'b1;
          state_nxt = ACTIVE;
        end else begin
          i_nxt   = '0;
          q_nxt   = '0;
          vld_nxt = 1'b0;
        end
      end
      ACTIVE: begin
        if (sample_cnt != CNT_LAST) begin
          cnt_nxt = sample_cnt + CNT_W'(1);
        end else if (symbol_valid) begin
          capture = 1'b1;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          i_nxt     = '0;
          q_nxt     = '0;
          vld_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (capture) begin
      cnt_nxt = '0;
      req_nxt = 1'b1;
      vld_nxt = 1'b1;
      i_nxt   = map_i(p_nxt);
      q_nxt   = map_q(p_nxt);
    end
  end

  // Control registers: FSM state and sample counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1   <= IDLE;
      sample_cnt <= '0;
    end else begin
      state_p1   <= state_nxt;
      sample_cnt <= cnt_nxt;
    end
  end

  // Output stage: registered I/Q, valid and consume pulse; zeroed on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_p1   <= '0;
      q_p1   <= '0;
      vld_p1 <= 1'b0;
      req_p1 <= 1'b0;
    end else begin
      i_p1   <= i_nxt;
      q_p1   <= q_nxt;
      vld_p1 <= vld_nxt;
      req_p1 <= req_nxt;
    end
  end

  assign i_out        = i_p1;
  assign q_out        = q_p1;
  assign sample_valid = vld_p1;
  assign mod_req      = req_p1;
  assign busy         = (state_p1 == ACTIVE);

endmodule

// File: tb/tb_qpsk_mapper.sv
// tb_qpsk_mapper: randomized burst stimulus with a queue-based scoreboard.
// The reference model derives each symbol's phase from the Gray rule (and the
// running phase sum when QPSK_DIFF_ENCODE_EN is defined) and expands it into
// SPS expected samples, the first one flagged with the consume pulse.
module tb_qpsk_mapper;
  localparam int SPS  = 4;
  localparam int IQ_W = 12;
  localparam int AMP  = 1448;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [1:0]             symbol_data;
  logic                   symbol_valid;
  logic                   mod_req;
  logic signed [IQ_W-1:0] i_out;
  logic signed [IQ_W-1:0] q_out;
  logic                   sample_valid;
  logic                   busy;

  qpsk_mapper #(.SPS(SPS), .IQ_W(IQ_W), .AMP(AMP)) dut (
    .clk          (clk),
    .reset        (reset),
    .symbol_data  (symbol_data),
    .symbol_valid (symbol_valid),
    .mod_req      (mod_req),
    .i_out        (i_out),
    .q_out        (q_out),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int i;
    int q;
    bit req;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] burst_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  bit         prev_req = 1'b0;
  int         req_cnt = 0;
  int         vld_cnt = 0;
  int         p_acc = 0;
  int         i_sign[4] = '{1, -1, -1, 1};
  int         q_sign[4] = '{1, 1, -1, -1};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Position of the dibit around the Gray-coded constellation circle.
  function automatic int gray(input logic [1:0] d);
    int order[4] = '{0, 1, 3, 2};
    for (int k = 0; k < 4; k++) if (order[k] == int'(d)) return k;
    return 0;
  endfunction

  task automatic push_symbol(input int p);
    exp_t e;
    for (int k = 0; k < SPS; k++) begin
      e.i   = i_sign[p] * AMP;
      e.q   = q_sign[p] * AMP;
      e.req = (k == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic present(input logic [1:0] s, input bit first);
    int g;
    g = gray(s);
`ifdef QPSK_DIFF_ENCODE_EN
    p_acc = first ? g : (p_acc + g) % 4;
`else
    p_acc = g;
`endif
    symbol_data  = s;
    symbol_valid = 1'b1;
    push_symbol(p_acc);
  endtask

  task automatic wait_req(output int t);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mod_req && t < 2 * SPS + 4);
    if (!mod_req) check("mod_req_timeout", 0, 1);
  endtask

  // Plays burst_q as one burst, upstream reacting to each consume pulse.
  task automatic run_burst(input bit settle);
    int t;
    int n;
    n = burst_q.size();
    present(burst_q[0], 1'b1);
    for (int i = 0; i < n; i++) begin
      wait_req(t);
      if (i == 0) check("first_req_latency", t, 1);
      else        check("req_period", t, SPS);
      if (i + 1 < n) present(burst_q[i + 1], 1'b0);
      else           symbol_valid = 1'b0;
    end
    t = 0;
    while (busy && t < 2 * SPS + 4) begin
      @(negedge clk);
      t++;
    end
    check("burst_end_busy", busy, 0);
    if (settle) @(negedge clk);
  endtask

  task automatic random_burst(input int n);
    burst_q.delete();
    for (int i = 0; i < n; i++) burst_q.push_back(2'($urandom_range(0, 3)));
  endtask

  // Monitor: pops one expectation per live sample, checks idle zeros otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (mod_req) check("req_back_to_back", int'(prev_req), 0);
        prev_req = mod_req;
        if (sample_valid) begin
          vld_cnt++;
          if (mod_req) req_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_sample", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("i_out", int'(i_out), e.i);
            check("q_out", int'(q_out), e.q);
            check("mod_req", int'(mod_req), int'(e.req));
          end
        end else begin
          check("idle_i_out", int'(i_out), 0);
          check("idle_q_out", int'(q_out), 0);
          check("idle_mod_req", int'(mod_req), 0);
        end
        check("busy_vs_valid", int'(busy), int'(sample_valid));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int v0;
    int t;
    reset        = 1'b1;
    symbol_valid = 1'b0;
    symbol_data  = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_i_out", int'(i_out), 0);
    check("reset_q_out", int'(q_out), 0);
    check("reset_mod_req", int'(mod_req), 0);
    check("reset_sample_valid", int'(sample_valid), 0);
    check("reset_busy", int'(busy), 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_valid", int'(sample_valid), 0);
    mon_en = 1'b1;

    // Directed constellation sweep.
    burst_q = '{2'b00, 2'b01, 2'b11, 2'b10};
    r0 = req_cnt; v0 = vld_cnt;
    run_burst(1'b1);
    check("sweep_pulses", req_cnt - r0, 4);
    check("sweep_samples", vld_cnt - v0, 4 * SPS);

    // Repeated dibit: constant phase, or rotating phase when differential.
    burst_q = '{2'b01, 2'b01, 2'b01, 2'b01};
    r0 = req_cnt; v0 = vld_cnt;
    run_burst(1'b1);
    check("repeat_pulses", req_cnt - r0, 4);
    check("repeat_samples", vld_cnt - v0, 4 * SPS);

    // Full 128-bit frame.
    random_burst(64);
    r0 = req_cnt; v0 = vld_cnt;
    run_burst(1'b1);
    check("frame_pulses", req_cnt - r0, 64);
    check("frame_samples", vld_cnt - v0, 64 * SPS);
    check("frame_idle_valid", int'(sample_valid), 0);

    // Valid dropped for exactly one boundary, then a new burst.
    r0 = req_cnt; v0 = vld_cnt;
    random_burst(3);
    run_burst(1'b0);
    check("gap_single_idle", int'(sample_valid), 0);
    random_burst(5);
    run_burst(1'b1);
    check("gap_pulses", req_cnt - r0, 8);
    check("gap_samples", vld_cnt - v0, 8 * SPS);

    // Random bursts with random idle spacing.
    for (int b = 0; b < 6; b++) begin
      int n;
      n = $urandom_range(1, 10);
      random_burst(n);
      r0 = req_cnt; v0 = vld_cnt;
      run_burst(1'b1);
      check("rand_pulses", req_cnt - r0, n);
      check("rand_samples", vld_cnt - v0, n * SPS);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in the middle of the second symbol at sample_cnt = 3.
    present(2'($urandom_range(0, 3)), 1'b1);
    wait_req(t);
    present(2'($urandom_range(0, 3)), 1'b0);
    wait_req(t);
    symbol_data = 2'($urandom_range(0, 3));
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("async_reset_i_out", int'(i_out), 0);
    check("async_reset_q_out", int'(q_out), 0);
    check("async_reset_valid", int'(sample_valid), 0);
    check("async_reset_mod_req", int'(mod_req), 0);
    check("async_reset_busy", int'(busy), 0);
    symbol_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    prev_req = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Fresh burst after reset release.
    random_burst(4);
    r0 = req_cnt; v0 = vld_cnt;
    run_burst(1'b1);
    check("post_reset_pulses", req_cnt - r0, 4);
    check("post_reset_samples", vld_cnt - v0, 4 * SPS);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qpsk_mapper.md
QPSK_MAPPER -- requirements
Module: qpsk_mapper

Interface
REQ-001 Parameter SPS, default 8, samples per symbol; legal range 2..256.
REQ-002 Parameter IQ_W, default 12, I/Q sample width in bits.
REQ-003 Parameter AMP, default 1448, signed constellation magnitude; must satisfy 0 < AMP < 2^(IQ_W-1).
REQ-004 Port clk, input, 1, single clock; all logic rising-edge.
REQ-005 Port reset, input, 1, asynchronous active-high reset.
REQ-006 Port symbol_data, input, 2, dibit from the serializer; bit 1 first-transmitted MSB.
REQ-007 Port symbol_valid, input, 1, symbol_data holds an unconsumed symbol.
REQ-008 Port mod_req, output, 1, one-cycle pulse: the presented symbol was consumed.
REQ-009 Port i_out, output, IQ_W, signed in-phase sample.
REQ-010 Port q_out, output, IQ_W, signed quadrature sample.
REQ-011 Port sample_valid, output, 1, i_out/q_out carry a live sample this cycle.
REQ-012 Port busy, output, 1, high while in state ACTIVE.

Function
REQ-013 States: IDLE and ACTIVE; the block also holds a sample counter sample_cnt (0..SPS-1) and a 2-bit phase index p.
REQ-014 IDLE, symbol_valid=1 at an edge -> capture symbol_data, go to ACTIVE, sample_cnt<=0, mod_req<=1, sample_valid<=1, I/Q<=map(p).
REQ-015 IDLE, symbol_valid=0 -> remain IDLE; i_out=q_out=0, sample_valid=0, mod_req=0.
REQ-016 ACTIVE, sample_cnt<SPS-1 -> sample_cnt+1; I/Q held; mod_req=0; symbol_valid ignored.
REQ-017 ACTIVE, sample_cnt=SPS-1, symbol_valid=1 -> capture the next symbol, sample_cnt<=0, mod_req<=1, I/Q updated; no gap samples.
REQ-018 ACTIVE, sample_cnt=SPS-1, symbol_valid=0 -> go to IDLE; I/Q<=0, sample_valid<=0, mod_req<=0 (end of burst, not an error).
REQ-019 All outputs are registered; I/Q for a symbol appear in the same cycle as its mod_req pulse, one cycle after the capturing edge.
REQ-020 mod_req is never high in two consecutive cycles; pulses are exactly SPS cycles apart within a burst (upstream updates symbol_data one cycle after seeing mod_req).
REQ-021 Each symbol is output for exactly SPS consecutive sample_valid cycles.
REQ-022 Gray index g(dibit): 00->0, 01->1, 11->2, 10->3.
REQ-023 map(p): 0->(+AMP,+AMP), 1->(-AMP,+AMP), 2->(-AMP,-AMP), 3->(+AMP,-AMP), sign-extended to IQ_W.
REQ-024 Without differential mode, p = g(captured dibit).
REQ-025 A burst of N symbols yields exactly N mod_req pulses and N*SPS valid samples.

Reset
REQ-026 reset high asynchronously forces IDLE, sample_cnt=0, p=0, mod_req=0, sample_valid=0, busy=0, i_out=q_out=0.
REQ-027 Reset mid-symbol aborts the burst immediately; the partial symbol is not resumed, and the first edge after release follows REQ-014/015.

Configuration
REQ-028 Macro QPSK_DIFF_ENCODE_EN defined: p<=(p+g(dibit)) mod 4 on every capture; p is cleared to 0 on reset and on every IDLE->ACTIVE transition, before the first symbol's addition.
REQ-029 QPSK_DIFF_ENCODE_EN undefined: p<=g(dibit); no accumulator state exists.

Verification
REQ-030 SPS=8, burst 00,01,11,10 (non-diff) -> I/Q (+1448,+1448),(-1448,+1448),(-1448,-1448),(+1448,-1448), 8 samples each, mod_req every 8 cycles, 32 valid samples.
REQ-031 Full 128-bit serializer frame, SPS=4 -> 64 mod_req pulses, 256 valid samples, then sample_valid=0, busy=0; upstream returns to ready.
REQ-032 SPS=2 minimum, continuous symbol_valid -> mod_req alternates 1,0,1,0; no symbol skipped or repeated.
REQ-033 QPSK_DIFF_ENCODE_EN, dibits 01,01,01,01 -> p=1,2,3,0 -> (-A,+A),(-A,-A),(+A,-A),(+A,+A); second burst restarts from p=0.
REQ-034 reset asserted at sample_cnt=3 of symbol 2 -> outputs zero in that cycle asynchronously; a fresh burst after release starts cleanly with mod_req one cycle after capture.
REQ-035 symbol_valid dropped for one cycle at the boundary -> return to IDLE, exactly one zero/invalid cycle, new burst resumes on the next valid.
